ms_tick_counter: RTL and testbench
==================================

# ms_tick_counter

Parametrised millisecond timebase counter; the next generation of the free-running 16-bit counter in the millisecond-counter datapath. An internal prescaler divides CLK into a tick (1 ms at the default divisor). A WIDTH-bit counter advances on each tick, with run/stop, up/down, synchronous load, modulo wrap or saturation, terminal-count and overflow flags, and a lap-capture register. It feeds the display/BCD path and any downstream cascade stage.

## Interface
- WIDTH, 16: counter width in bits (≥2).
- TICK_DIV, 50000: CLK cycles per tick (≥1); 50000 gives 1 ms at 50 MHz.
- MODULUS, 0: count range. 0 means full 2^WIDTH; otherwise 2..2^WIDTH, so MAX = MODULUS-1.
- SATURATE, 0: 0 wraps at boundary; 1 holds at boundary.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  run enable; 0 freezes prescaler and counter.
- CLR  in  1  synchronous clear of counter, prescaler and OVF.
- DIR  in  1  0 = count up, 1 = count down.
- LOAD  in  1  synchronous load of LOAD_VAL.
- LOAD_VAL  in  WIDTH  load value.
- CAPTURE  in  1  lap capture request.
- OVF_CLR  in  1  clears sticky OVF.
- Q  out  WIDTH  counter value (registered).
- TICK  out  1  one-cycle pulse on each counter advance.
- TC  out  1  one-cycle terminal-count pulse.
- OVF  out  1  sticky wrap/saturation flag.
- CAP_Q  out  WIDTH  captured counter value.
- CAP_VALID  out  1  one-cycle pulse, asserted the cycle CAP_Q updates.

## Operation
- Reset values: Q=0, prescaler PS=0, TICK=0, TC=0, OVF=0, CAP_Q=0, CAP_VALID=0.
- Edge priority: RST > CLR > LOAD > tick advance.
- Prescaler: PS counts 0..TICK_DIV-1 while EN=1 and holds while EN=0.
- Tick event: an edge where EN=1 and PS==TICK_DIV-1. On that edge PS goes to 0, Q takes its next value and TICK is set to 1. On all other edges TICK is 0.
- Next value, up (DIR=0):
  - Q==MAX: Q becomes 0 if SATURATE=0, holds MAX if SATURATE=1.
  - Otherwise Q+1.
- Next value, down (DIR=1):
  - Q==0: Q becomes MAX if SATURATE=0, holds 0 if SATURATE=1.
  - Otherwise Q-1.
- Boundary: Q==MAX when counting up, Q==0 when counting down. On a tick event where Q was at its boundary, TC=1 and OVF is set to 1. This repeats on every such tick while saturated.
- CLR: Q=0, PS=0, OVF=0. TICK and TC are 0 that edge. Honoured regardless of EN.
- LOAD: Q=min(LOAD_VAL, MAX), PS=0, no tick that edge. Honoured regardless of EN.
- OVF_CLR clears OVF. If a boundary tick occurs on the same edge, the set wins and OVF=1.
- CAPTURE: CAP_Q takes the value Q held before the edge, and CAP_VALID=1 for one cycle. This is independent of EN, CLR and LOAD; it is blocked only by RST.
- DIR and EN are sampled on every edge; a DIR change applies at the next tick event.
- MODULUS=0 with SATURATE=0 reproduces the plain free-running WIDTH-bit counter, scaled by TICK_DIV.

## Timing
- From reset release with EN held high, the first TICK and the first Q change occur on the TICK_DIV-th edge. The period is then exactly TICK_DIV cycles.
- TICK_DIV=1: tick on every enabled edge.
- Q, TICK and TC change on the same edge. TC and TICK are never high without each other's tick event.
- Deasserting EN for N cycles stretches the current tick period by exactly N cycles; the PS phase is preserved.
- CLR or LOAD restarts the prescaler phase: the next tick is TICK_DIV enabled edges later.
- CAP_Q and CAP_VALID are valid one cycle after the CAPTURE sample edge, i.e. registered.
- RST asserted mid-count forces all outputs to reset values on that edge.

## Test plan
- WIDTH=4, TICK_DIV=4, MODULUS=10, SATURATE=0, EN=1, DIR=0 for 44 cycles → TICK every 4th edge; Q runs 0..9, 0. TC and OVF set on the tick where Q goes 9→0. Q=1 at the end.
- Same config, DIR=1 from Q=0 → next tick gives Q=9, TC=1, OVF=1; OVF_CLR then clears it.
- SATURATE=1, MODULUS=0, WIDTH=4, LOAD_VAL=15 then ticks up → Q holds 15, TC pulses on every tick. LOAD_VAL=20 with MODULUS=10 → Q=9.
- EN drops for 3 cycles mid-period at PS=2 → next TICK arrives 3 cycles late; Q is unchanged while EN=0.
- CLR and a tick event on the same edge → Q=0, TICK=0, TC=0. CAPTURE on that edge → CAP_Q equals the pre-clear Q, CAP_VALID pulses once.
- RST asserted mid-count with LOAD and CAPTURE high → all outputs 0; counting resumes from 0 after release.

Source files
------------

// File: rtl/ms_tick_counter.sv
// Millisecond timebase: a prescaler divides CLK into ticks, and a WIDTH-bit
// up/down counter advances on each tick with wrap/saturate, flags and lap capture.
module ms_tick_counter #(
   parameter int WIDTH    = 16,
   parameter int TICK_DIV = 50000,
   parameter int MODULUS  = 0,
   parameter int SATURATE = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             CLR,
   input  logic             DIR,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   input  logic             CAPTURE,
   input  logic             OVF_CLR,
   output logic [WIDTH-1:0] Q,
   output logic             TICK,
   output logic             TC,
   output logic             OVF,
   output logic [WIDTH-1:0] CAP_Q,
   output logic             CAP_VALID
);

   localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
   localparam logic [WIDTH-1:0] MAX    = (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);

   function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] q, input logic down);
      if (!down) begin
         if (q == MAX) return (SATURATE != 0) ? MAX : '0;
         return q + WIDTH'(1);
      end
      if (q == '0) return (SATURATE != 0) ? '0 : MAX;
      return q - WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      return (v > MAX) ? MAX : v;
   endfunction

   logic [PS_W-1:0]  r_ps;
   logic [WIDTH-1:0] r_q;
   logic             r_tick;
   logic             r_tc;
   logic             r_ovf;
   logic [WIDTH-1:0] r_cap_q;
   logic             r_cap_valid;

   logic             w_tick;
   logic             w_bnd;
   logic [WIDTH-1:0] w_q_next;

   assign w_tick   = EN && (r_ps == PS_LAST);
   assign w_bnd    = DIR ? (r_q == '0) : (r_q == MAX);
   assign w_q_next = next_val(r_q, DIR);

   // Counter stage: CLR beats LOAD beats a tick advance; a boundary tick beats OVF_CLR.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ps   <= '0;
         r_q    <= '0;
         r_tick <= 1'b0;
         r_tc   <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         r_tc   <= 1'b0;
         if (CLR) begin
            r_q   <= '0;
            r_ps  <= '0;
            r_ovf <= 1'b0;
         end else if (LOAD) begin
            r_q  <= clamp_load(LOAD_VAL);
            r_ps <= '0;
            if (OVF_CLR) r_ovf <= 1'b0;
         end else begin
            if (EN) r_ps <= w_tick ? '0 : r_ps + PS_W'(1);
            if (w_tick) begin
               r_q    <= w_q_next;
               r_tick <= 1'b1;
               r_tc   <= w_bnd;
            end
            if (w_tick && w_bnd) r_ovf <= 1'b1;
            else if (OVF_CLR)    r_ovf <= 1'b0;
         end
      end
   end

   // Lap capture stage: samples the pre-edge count, independent of CLR/LOAD/EN.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cap_q     <= '0;
         r_cap_valid <= 1'b0;
      end else begin
         r_cap_valid <= CAPTURE;
         if (CAPTURE) r_cap_q <= r_q;
      end
   end

   assign Q         = r_q;
   assign TICK      = r_tick;
   assign TC        = r_tc;
   assign OVF       = r_ovf;
   assign CAP_Q     = r_cap_q;
   assign CAP_VALID = r_cap_valid;

endmodule

// File: tb/tb_ms_tick_counter.sv
// Scoreboard bench for ms_tick_counter: three configurations, expected ticks and
// captures queued by the stimulus, checked by a monitor whenever TICK/CAP_VALID fire.
module tb_ms_tick_counter;

   typedef struct { int edge_n; int q; int tc; int ovf; } tick_e;
   typedef struct { int edge_n; int v; } cap_e;

   logic CLK = 1'b0;
   logic RST;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   tick_e tq[3][$];
   cap_e  cq[3][$];
   string dn[3] = '{"A", "B", "C"};

   // A: W4 DIV4 MOD10 wrap; B: W4 DIV4 full range saturate; C: W5 DIV1 MOD10 saturate
   logic       a_en, a_clr, a_dir, a_load, a_cap, a_oclr;
   logic [3:0] a_lv, a_q, a_capq;
   logic       a_tick, a_tc, a_ovf, a_capv;
   logic       b_en, b_clr, b_dir, b_load, b_cap, b_oclr;
   logic [3:0] b_lv, b_q, b_capq;
   logic       b_tick, b_tc, b_ovf, b_capv;
   logic       c_en, c_clr, c_dir, c_load, c_cap, c_oclr;
   logic [4:0] c_lv, c_q, c_capq;
   logic       c_tick, c_tc, c_ovf, c_capv;

   ms_tick_counter #(.WIDTH(4), .TICK_DIV(4), .MODULUS(10), .SATURATE(0)) dut_a (
      .CLK(CLK), .RST(RST), .EN(a_en), .CLR(a_clr), .DIR(a_dir), .LOAD(a_load),
      .LOAD_VAL(a_lv), .CAPTURE(a_cap), .OVF_CLR(a_oclr), .Q(a_q), .TICK(a_tick),
      .TC(a_tc), .OVF(a_ovf), .CAP_Q(a_capq), .CAP_VALID(a_capv));

   ms_tick_counter #(.WIDTH(4), .TICK_DIV(4), .MODULUS(0), .SATURATE(1)) dut_b (
      .CLK(CLK), .RST(RST), .EN(b_en), .CLR(b_clr), .DIR(b_dir), .LOAD(b_load),
      .LOAD_VAL(b_lv), .CAPTURE(b_cap), .OVF_CLR(b_oclr), .Q(b_q), .TICK(b_tick),
      .TC(b_tc), .OVF(b_ovf), .CAP_Q(b_capq), .CAP_VALID(b_capv));

   ms_tick_counter #(.WIDTH(5), .TICK_DIV(1), .MODULUS(10), .SATURATE(1)) dut_c (
      .CLK(CLK), .RST(RST), .EN(c_en), .CLR(c_clr), .DIR(c_dir), .LOAD(c_load),
      .LOAD_VAL(c_lv), .CAPTURE(c_cap), .OVF_CLR(c_oclr), .Q(c_q), .TICK(c_tick),
      .TC(c_tc), .OVF(c_ovf), .CAP_Q(c_capq), .CAP_VALID(c_capv));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   function automatic tick_e te(input int e, input int q, input int tc, input int ovf);
      tick_e r;
      r.edge_n = e; r.q = q; r.tc = tc; r.ovf = ovf;
      return r;
   endfunction

   function automatic cap_e ce(input int e, input int v);
      cap_e r;
      r.edge_n = e; r.v = v;
      return r;
   endfunction

   task automatic mon(input int d, input logic tick, input logic tc, input logic ovf,
                      input logic [31:0] q, input logic capv, input logic [31:0] capq);
      tick_e e;
      cap_e  c;
      if (tc && !tick) chk({dn[d], "_tc_without_tick"}, tc, 0);
      if (tick) begin
         if (tq[d].size() == 0) chk({dn[d], "_tick_expected"}, tick, 0);
         else begin
            e = tq[d].pop_front();
            chk({dn[d], "_tick_edge"}, cyc, e.edge_n);
            chk({dn[d], "_q"}, q, e.q);
            chk({dn[d], "_tc"}, tc, e.tc);
            chk({dn[d], "_ovf"}, ovf, e.ovf);
         end
      end else if (tq[d].size() != 0 && tq[d][0].edge_n <= cyc) begin
         e = tq[d].pop_front();
         chk({dn[d], "_tick_present"}, tick, 1);
      end
      if (capv) begin
         if (cq[d].size() == 0) chk({dn[d], "_cap_expected"}, capv, 0);
         else begin
            c = cq[d].pop_front();
            chk({dn[d], "_cap_edge"}, cyc, c.edge_n);
            chk({dn[d], "_cap_q"}, capq, c.v);
         end
      end else if (cq[d].size() != 0 && cq[d][0].edge_n <= cyc) begin
         c = cq[d].pop_front();
         chk({dn[d], "_cap_valid"}, capv, 1);
      end
   endtask

   always @(negedge CLK) begin
      mon(0, a_tick, a_tc, a_ovf, a_q, a_capv, a_capq);
      mon(1, b_tick, b_tc, b_ovf, b_q, b_capv, b_capq);
      mon(2, c_tick, c_tc, c_ovf, c_q, c_capv, c_capq);
   end

   task automatic nx(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete, edge %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      RST = 1'b1;
      {a_en, a_clr, a_dir, a_load, a_cap, a_oclr} = '0; a_lv = '0;
      {b_en, b_clr, b_dir, b_load, b_cap, b_oclr} = '0; b_lv = '0;
      {c_en, c_clr, c_dir, c_load, c_cap, c_oclr} = '0; c_lv = '0;
      nx(2);
      chk("rst_q", a_q, 0);
      chk("rst_tick", a_tick, 0);
      chk("rst_tc", a_tc, 0);
      chk("rst_ovf", a_ovf, 0);
      chk("rst_cap_q", a_capq, 0);
      chk("rst_cap_valid", a_capv, 0);

      // A: 44 cycles counting up, wrap 9->0 on the 10th tick
      RST = 1'b0; a_en = 1'b1; t = cyc;
      for (int k = 1; k <= 11; k++)
         tq[0].push_back(te(t + 4 * k, k % 10, (k == 10) ? 1 : 0, (k >= 10) ? 1 : 0));
      nx(44);

      // A: CLR on a tick edge with CAPTURE; Q was 1
      t = cyc; nx(3);
      a_clr = 1'b1; a_cap = 1'b1; cq[0].push_back(ce(t + 4, 1));
      nx(1); a_clr = 1'b0; a_cap = 1'b0;

      // A: count down from 0 wraps to 9, then OVF_CLR
      t = cyc; a_dir = 1'b1;
      tq[0].push_back(te(t + 4, 9, 1, 1));
      tq[0].push_back(te(t + 8, 8, 0, 1));
      nx(9); a_oclr = 1'b1;
      tq[0].push_back(te(t + 12, 7, 0, 0));
      nx(1); a_oclr = 1'b0;
      nx(2);

      // A: EN low for 3 cycles at PS=2 delays the tick by 3
      t = cyc; nx(2); a_en = 1'b0;
      nx(2); chk("A_q_stalled", a_q, 7);
      nx(1); a_en = 1'b1; tq[0].push_back(te(t + 7, 6, 0, 0));
      nx(2);

      // A: RST mid-count with LOAD and CAPTURE high
      nx(1); RST = 1'b1; a_load = 1'b1; a_lv = 4'd5; a_cap = 1'b1;
      nx(1); RST = 1'b0; a_load = 1'b0; a_cap = 1'b0; a_dir = 1'b0;
      chk("A_rst_q", a_q, 0);
      chk("A_rst_tick", a_tick, 0);
      chk("A_rst_ovf", a_ovf, 0);
      chk("A_rst_cap_q", a_capq, 0);
      chk("A_rst_cap_valid", a_capv, 0);
      t = cyc; tq[0].push_back(te(t + 4, 1, 0, 0));
      nx(4);

      // A: LOAD 15 clamps to 9; boundary tick wins over OVF_CLR
      t = cyc; a_load = 1'b1; a_lv = 4'd15;
      nx(1); a_load = 1'b0; a_cap = 1'b1; cq[0].push_back(ce(t + 2, 9));
      nx(1); a_cap = 1'b0;
      nx(2); a_oclr = 1'b1; tq[0].push_back(te(t + 5, 0, 1, 1));
      nx(1); a_oclr = 1'b0; tq[0].push_back(te(t + 9, 1, 0, 1));
      nx(4); a_en = 1'b0;

      // B: saturating full range, hold at 15 then at 0
      t = cyc; b_load = 1'b1; b_lv = 4'd15;
      nx(1); b_load = 1'b0; b_en = 1'b1;
      for (int k = 1; k <= 3; k++) tq[1].push_back(te(t + 1 + 4 * k, 15, 1, 1));
      nx(12); b_dir = 1'b1; tq[1].push_back(te(t + 17, 14, 0, 1));
      nx(4); b_load = 1'b1; b_lv = 4'd0;
      nx(1); b_load = 1'b0; tq[1].push_back(te(t + 22, 0, 1, 1));
      nx(4); b_en = 1'b0;

      // C: LOAD 20 clamps to 9; TICK_DIV=1 ticks every enabled edge
      t = cyc; c_load = 1'b1; c_lv = 5'd20;
      nx(1); c_load = 1'b0; c_cap = 1'b1; cq[2].push_back(ce(t + 2, 9));
      nx(1); c_cap = 1'b0; c_en = 1'b1;
      tq[2].push_back(te(t + 3, 9, 1, 1));
      tq[2].push_back(te(t + 4, 9, 1, 1));
      nx(2); c_dir = 1'b1;
      tq[2].push_back(te(t + 5, 8, 0, 1));
      tq[2].push_back(te(t + 6, 7, 0, 1));
      nx(2); c_en = 1'b0;

      nx(4);
      for (int d = 0; d < 3; d++) begin
         chk({dn[d], "_ticks_outstanding"}, tq[d].size(), 0);
         chk({dn[d], "_caps_outstanding"}, cq[d].size(), 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
